// File: rtl/sincronizador_antirrebote.sv
// sincronizador_antirrebote: per-channel synchroniser, debouncer and rise/fall pulse generator.
// Optional auto-repeat of rise pulses while held: define SINCRONIZADOR_AUTOREPEAT_EN.
module sincronizador_antirrebote #(
    parameter int N_CH          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CW-1:0]          r_cnt;
        logic                   r_level;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;
        logic                   w_diff;
        logic                   w_accept;
        logic                   w_rep_fire;
        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_diff   = w_s != r_level;
        assign w_accept = w_diff && (r_cnt == CNT_LAST);
`ifdef SINCRONIZADOR_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX + 1);
        logic [RW-1:0] r_rep_cnt;
        logic          r_rep_phase;
        logic [RW-1:0] w_rep_last;
        // Phase 0 waits the initial delay after the real rise, phase 1 the period.
        assign w_rep_last = r_rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
        assign w_rep_fire = r_level && !w_accept && (r_rep_cnt == w_rep_last);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
            end else if (!r_level || w_accept) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + 1'b1;
            end
        end
`else
        assign w_rep_fire = 1'b0;
`endif
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync  <= '0;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], din[i]};
                r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
                r_level <= w_accept ? w_s : r_level;
                r_rise  <= (w_accept && w_s) || w_rep_fire;
                r_fall  <= w_accept && !w_s;
            end
        end
        assign level[i] = r_level;
        assign rise[i]  = r_rise;
        assign fall[i]  = r_fall;
    end
endmodule
